data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Clocked, parametrised single-port data memory for the CPU datapath: word width, depth and byte-lane writes.
//  Valid/ready request channel; read data returns one cycle later as a rsp_valid pulse.
//  Zeroes every location after reset, or on clear_req, via an internal sweep FSM.
//  Flags out-of-range addresses instead of aliasing them.
// PARAMETERS
//  DATA_W   8    word width in bits; must be a multiple of 8 (LANES = DATA_W/8)
//  DEPTH    256  number of words; need not be a power of 2
//  ADDR_W   8    address width; must satisfy 2**ADDR_W >= DEPTH
// PORTS
//  clk         in   1        single clock, rising edge
//  rst_n       in   1        asynchronous, active-low reset
//  clear_req   in   1        pulse: start a zeroing sweep
//  req_valid   in   1        request present
//  req_ready   out  1        request accepted when valid && ready
//  req_write   in   1        1 = write, 0 = read
//  req_addr    in   ADDR_W   word address
//  req_wdata   in   DATA_W   write data
//  req_wmask   in   LANES    per-byte write enable; bit i covers bits [8i+7:8i]
//  rsp_valid   out  1        one-cycle pulse carrying the read result
//  rsp_data    out  DATA_W   read data; holds its value between pulses
//  rsp_err     out  1        qualifies rsp_valid/wr_done: address >= DEPTH
//  wr_done     out  1        one-cycle pulse the cycle after a write is accepted
//  busy        out  1        high while the clear sweep runs
// BEHAVIOUR
//  - States: CLEAR, READY (2-bit encoding from the package).
//  - Reset (async assert, sync release): state=CLEAR, clr_cnt=0.
//  - Reset values of outputs: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, wr_done=0, busy=1.
//  - Array contents are not reset; the sweep zeroes them.
//  - CLEAR: one word per cycle writes all-zero (all lanes) at clr_cnt, then clr_cnt++.
//    - After writing DEPTH-1, go to READY.
//    - The sweep takes exactly DEPTH cycles. busy=1 and req_ready=0 throughout.
//  - READY: req_ready = !clear_req (combinational).
//    - clear_req in READY -> CLEAR with clr_cnt=0 next cycle; a same-cycle request is not accepted.
//    - clear_req during CLEAR restarts the sweep at clr_cnt=0.
//  - Accepted write: lanes with req_wmask=1 are updated at the clock edge; other lanes keep their old data.
//    - wr_done=1 next cycle. wmask=0 is legal: wr_done still pulses and no data changes.
//  - Accepted read: rsp_valid=1 next cycle, with rsp_data = array[addr] sampled at the accept edge.
//    - Back-to-back reads give one response per cycle, at full throughput.
//  - A read the cycle after a write to the same address returns the new data (write completes first).
//  - addr >= DEPTH:
//    - write: array is unchanged; wr_done=1 with rsp_err=1.
//    - read: rsp_data=0 with rsp_valid=1 and rsp_err=1.
//  - rsp_err is 0 whenever rsp_valid and wr_done are both 0.
//  - Reset mid-read drops the pending rsp_valid. Reset mid-sweep restarts the sweep from 0.
// CONFIGURATION
//  DMEM_PARITY_EN defined:
//    - One even-parity bit is stored per lane. A written lane stores ^data_lane; the sweep stores 0.
//    - Extra input perr_inj (1 bit): when 1 on an accepted write, the stored parity of the written lanes is inverted.
//    - Extra output rsp_perr (1 bit, reset 0): asserted with rsp_valid when any lane's recomputed parity mismatches; 0 otherwise.
//  DMEM_PARITY_EN undefined: no parity storage and no perr_inj/rsp_perr ports; behaviour is otherwise identical.
// STRUCTURE
//  - Package data_memory_pkg holds:
//    - state enum dmem_state_t {CLEAR, READY}
//    - localparam LANE_W=8
//    - function lane_parity(data, lane)
//  - Sub-module dmem_array: storage only (DATA_W (+LANES) x DEPTH), one write port with lane enables and one synchronous read port.
//  - The top holds the FSM, clr_cnt, range check, response registers and parity logic.
// TESTING
//  1. Reset, DEPTH=256: busy=1 for exactly 256 cycles; then req_ready=1; read addr 0x3F -> rsp_valid next cycle, data 0x00.
//  2. DATA_W=32: write 0xAABBCCDD mask 4'b1111, then 0x11223344 mask 4'b0101 to addr 5; read 5 -> 0xAA22CC44.
//  3. DEPTH=200: write addr 210 -> wr_done=1, rsp_err=1; read 210 -> data 0, rsp_err=1; read 199 -> rsp_err=0.
//  4. Write 0x5A to addr 7 then read 7 on the next cycle -> 0x5A; back-to-back reads of 7, 8, 9 -> three consecutive rsp_valid pulses.
//  5. clear_req pulsed with req_valid high in READY -> request not accepted, busy for DEPTH cycles, all data reads 0 afterwards.
//     rst_n pulled low mid-sweep -> outputs at reset values, sweep restarts.
//  6. DMEM_PARITY_EN: write 0x0F with perr_inj=1, read -> rsp_perr=1; rewrite with perr_inj=0, read -> rsp_perr=0.

Source files
------------

// File: rtl/data_memory_pkg.sv
// Shared types and helpers for the data memory controller.
// Optional feature macro: DMEM_PARITY_EN (per-lane even parity storage).
package data_memory_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    READY = 2'd1
  } dmem_state_t;

  localparam int LANE_W     = 8;
  // Widest word the parity helper accepts; callers zero-extend into it.
  localparam int DMEM_MAX_W = 1024;

  // Even parity of one byte lane of a (zero-extended) data word.
  function automatic logic lane_parity(input logic [DMEM_MAX_W-1:0] data, input int lane);
    return ^data[lane*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/data_memory_if.sv
// Request/response bus of the data memory controller.
// master = requester (CPU side), slave = memory controller.
interface data_memory_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  localparam int LANES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [LANES-1:0]  req_wmask;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic              wr_done;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_data, rsp_err, wr_done
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_data, rsp_err, wr_done
  );
endinterface

// File: rtl/data_memory_ctrl_array.sv
// Storage for the data memory: one lane-enabled write port and one
// registered read port. The array itself has no reset; only the read
// register does, so the response path starts at zero.
// Optional feature macro: DMEM_PARITY_EN (one parity bit per lane above the data).
module dmem_array
  import data_memory_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int WORD_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W/LANE_W-1:0] wr_lane,
  input  logic [WORD_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [WORD_W-1:0]        rd_data
);
  localparam int LANES = DATA_W / LANE_W;

  logic [WORD_W-1:0] mem [DEPTH];

  // Write port: each enabled lane updates its byte (and its parity bit when present).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_lane[i]) begin
          mem[wr_addr][i*LANE_W +: LANE_W] <= wr_data[i*LANE_W +: LANE_W];
`ifdef DMEM_PARITY_EN
          mem[wr_addr][DATA_W+i] <= wr_data[DATA_W+i];
`endif
        end
      end
    end
  end

  // Read port: registered, updated only on an in-range read so it holds between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-port data memory controller: valid/ready requests, one-cycle read
// latency, lane-masked writes, out-of-range flagging and a zeroing sweep
// after reset or on clear_req.
// Optional feature macro: DMEM_PARITY_EN (adds perr_inj / rsp_perr).
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_req,
  output logic busy,
`ifdef DMEM_PARITY_EN
  input  logic perr_inj,
  output logic rsp_perr,
`endif
  data_memory_if.slave bus
);
  localparam int LANES = DATA_W / LANE_W;
`ifdef DMEM_PARITY_EN
  localparam int WORD_W = DATA_W + LANES;
`else
  localparam int WORD_W = DATA_W;
`endif
  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  dmem_state_t       state, state_nxt;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_nxt;

  logic              in_range;
  logic              acc, acc_wr, acc_rd;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [LANES-1:0]  wr_lane;
  logic [WORD_W-1:0] wr_word, req_word;
  logic              rd_en;
  logic [WORD_W-1:0] rd_word;
  logic              rsp_valid_q, wr_done_q, rsp_err_q, rd_zero_q;

  assign in_range      = ({1'b0, bus.req_addr} < DEPTH_X);
  assign busy          = (state == CLEAR);
  assign bus.req_ready = (state == READY) && !clear_req;
  assign acc           = bus.req_valid && bus.req_ready;
  assign acc_wr        = acc && bus.req_write;
  assign acc_rd        = acc && !bus.req_write;
  assign rd_en         = acc_rd && in_range;

  // Write word for a request; parity bits (when present) follow the written lanes.
  always_comb begin
    req_word = '0;
    req_word[DATA_W-1:0] = bus.req_wdata;
`ifdef DMEM_PARITY_EN
    for (int i = 0; i < LANES; i++)
      req_word[DATA_W+i] = lane_parity(DMEM_MAX_W'(bus.req_wdata), i) ^ perr_inj;
`endif
  end

  // FSM state and sweep counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  // Next state and array write-port steering: the sweep owns the port in CLEAR.
  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    wr_en       = 1'b0;
    wr_addr     = bus.req_addr;
    wr_lane     = bus.req_wmask;
    wr_word     = req_word;
    case (state)
      CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = clr_cnt;
        wr_lane = '1;
        wr_word = '0;
        if (clear_req) begin
          clr_cnt_nxt = '0;
        end else if (clr_cnt == LAST_IDX) begin
          state_nxt   = READY;
          clr_cnt_nxt = '0;
        end else begin
          clr_cnt_nxt = clr_cnt + 1'b1;
        end
      end
      READY: begin
        wr_en = acc_wr && in_range;
        if (clear_req) begin
          state_nxt   = CLEAR;
          clr_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt   = CLEAR;
        clr_cnt_nxt = '0;
      end
    endcase
  end

  // Response pulses; rd_zero_q remembers whether the last read was out of range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      wr_done_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_zero_q   <= 1'b0;
    end else begin
      rsp_valid_q <= acc_rd;
      wr_done_q   <= acc_wr;
      rsp_err_q   <= acc && !in_range;
      if (acc_rd) rd_zero_q <= !in_range;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.wr_done   = wr_done_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rd_zero_q ? '0 : rd_word[DATA_W-1:0];

`ifdef DMEM_PARITY_EN
  // Recompute each lane's parity on the returned word and compare with the stored bit.
  always_comb begin
    rsp_perr = 1'b0;
    if (rsp_valid_q && !rd_zero_q)
      for (int i = 0; i < LANES; i++)
        if (lane_parity(DMEM_MAX_W'(rd_word[DATA_W-1:0]), i) != rd_word[DATA_W+i])
          rsp_perr = 1'b1;
  end
`endif

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_lane (wr_lane),
    .wr_data (wr_word),
    .rd_en   (rd_en),
    .rd_addr (bus.req_addr),
    .rd_data (rd_word)
  );

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: DUT a is 8-bit x 256 words, DUT b is 32-bit x 200 words.
module tb_data_memory_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic clear_req_a, clear_req_b;
  logic busy_a, busy_b;
`ifdef DMEM_PARITY_EN
  logic perr_inj_a, perr_inj_b;
  logic rsp_perr_a, rsp_perr_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  data_memory_if #(.DATA_W(8),  .ADDR_W(8)) if_a ();
  data_memory_if #(.DATA_W(32), .ADDR_W(8)) if_b ();

  data_memory_ctrl #(.DATA_W(8), .DEPTH(256), .ADDR_W(8)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req_a),
    .busy      (busy_a),
`ifdef DMEM_PARITY_EN
    .perr_inj  (perr_inj_a),
    .rsp_perr  (rsp_perr_a),
`endif
    .bus       (if_a.slave)
  );

  data_memory_ctrl #(.DATA_W(32), .DEPTH(200), .ADDR_W(8)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (clear_req_b),
    .busy      (busy_b),
`ifdef DMEM_PARITY_EN
    .perr_inj  (perr_inj_b),
    .rsp_perr  (rsp_perr_b),
`endif
    .bus       (if_b.slave)
  );

  task automatic idle_all();
    if_a.req_valid = 1'b0; if_a.req_write = 1'b0; if_a.req_addr = '0;
    if_a.req_wdata = '0;   if_a.req_wmask = '0;
    if_b.req_valid = 1'b0; if_b.req_write = 1'b0; if_b.req_addr = '0;
    if_b.req_wdata = '0;   if_b.req_wmask = '0;
  endtask

  // One request on DUT a (sel_b=0) or b (sel_b=1); returns at the negedge where the response is visible.
  task automatic issue(input bit sel_b, input bit wr, input logic [7:0] addr,
                       input logic [31:0] data, input logic [3:0] mask);
    @(negedge clk);
    if (sel_b) begin
      if_b.req_valid = 1'b1; if_b.req_write = wr; if_b.req_addr = addr;
      if_b.req_wdata = data; if_b.req_wmask = mask;
    end else begin
      if_a.req_valid = 1'b1; if_a.req_write = wr; if_a.req_addr = addr;
      if_a.req_wdata = data[7:0]; if_a.req_wmask = mask[0];
    end
    @(negedge clk);
    idle_all();
  endtask

  // Counts negedge samples with busy high over a fixed window starting now.
  task automatic count_busy(output int cnt_a, output int cnt_b);
    cnt_a = 0; cnt_b = 0;
    for (int k = 0; k < 300; k++) begin
      if (busy_a) cnt_a++;
      if (busy_b) cnt_b++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int ca, cb;
    #2;
    n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy_a); end
    n_checks++; if (if_a.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", if_a.req_ready); end
    n_checks++; if ({if_a.rsp_valid, if_a.rsp_err, if_a.wr_done} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 000", {if_a.rsp_valid, if_a.rsp_err, if_a.wr_done}); end
    n_checks++; if (if_a.rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", if_a.rsp_data); end
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(ca, cb);
    n_checks++; if (ca != 256) begin n_fail++; $display("FAIL sweep_len_a: got %0d want 256", ca); end
    n_checks++; if (cb != 200) begin n_fail++; $display("FAIL sweep_len_b: got %0d want 200", cb); end
    n_checks++; if (if_a.req_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_sweep: got %b want 1", if_a.req_ready); end
    issue(1'b0, 1'b0, 8'h3F, 32'h0, 4'h0);
    n_checks++; if (if_a.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rd3f_valid: got %b want 1", if_a.rsp_valid); end
    n_checks++; if (if_a.rsp_data !== 8'h00) begin n_fail++; $display("FAIL rd3f_data: got %h want 00", if_a.rsp_data); end
    @(negedge clk);
    n_checks++; if (if_a.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse_len: got %b want 0", if_a.rsp_valid); end
  endtask

  task automatic test_lane_mask();
    issue(1'b1, 1'b1, 8'd5, 32'hAABBCCDD, 4'b1111);
    n_checks++; if (if_b.wr_done !== 1'b1) begin n_fail++; $display("FAIL wr_done_full: got %b want 1", if_b.wr_done); end
    issue(1'b1, 1'b1, 8'd5, 32'h11223344, 4'b0101);
    issue(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
    n_checks++; if (if_b.rsp_data !== 32'hAA22CC44) begin n_fail++; $display("FAIL lane_merge: got %h want aa22cc44", if_b.rsp_data); end
    issue(1'b1, 1'b1, 8'd5, 32'hFFFFFFFF, 4'b0000);
    n_checks++; if ({if_b.wr_done, if_b.rsp_err} !== 2'b10) begin
      n_fail++; $display("FAIL wmask0_done: got %b want 10", {if_b.wr_done, if_b.rsp_err}); end
    issue(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
    n_checks++; if (if_b.rsp_data !== 32'hAA22CC44) begin n_fail++; $display("FAIL wmask0_nochange: got %h want aa22cc44", if_b.rsp_data); end
  endtask

  task automatic test_out_of_range();
    issue(1'b1, 1'b1, 8'd210, 32'h12345678, 4'hF);
    n_checks++; if ({if_b.wr_done, if_b.rsp_err} !== 2'b11) begin
      n_fail++; $display("FAIL oor_write: got %b want 11", {if_b.wr_done, if_b.rsp_err}); end
    @(negedge clk);
    n_checks++; if (if_b.rsp_err !== 1'b0) begin n_fail++; $display("FAIL err_idle: got %b want 0", if_b.rsp_err); end
    issue(1'b1, 1'b0, 8'd210, 32'h0, 4'h0);
    n_checks++; if ({if_b.rsp_valid, if_b.rsp_err, if_b.rsp_data} !== {2'b11, 32'h0}) begin
      n_fail++; $display("FAIL oor_read: got %b %b %h want 1 1 00000000", if_b.rsp_valid, if_b.rsp_err, if_b.rsp_data); end
    issue(1'b1, 1'b0, 8'd10, 32'h0, 4'h0);
    n_checks++; if (if_b.rsp_data !== 32'h0) begin n_fail++; $display("FAIL oor_alias: got %h want 00000000", if_b.rsp_data); end
    issue(1'b1, 1'b0, 8'd199, 32'h0, 4'h0);
    n_checks++; if ({if_b.rsp_valid, if_b.rsp_err} !== 2'b10) begin
      n_fail++; $display("FAIL last_addr_err: got %b want 10", {if_b.rsp_valid, if_b.rsp_err}); end
    issue(1'b1, 1'b1, 8'd199, 32'hCAFEF00D, 4'hF);
    issue(1'b1, 1'b0, 8'd199, 32'h0, 4'h0);
    n_checks++; if (if_b.rsp_data !== 32'hCAFEF00D) begin n_fail++; $display("FAIL last_addr_data: got %h want cafef00d", if_b.rsp_data); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h5A; exp_d[1] = 8'h11; exp_d[2] = 8'h22;
    @(negedge clk);
    if_a.req_valid = 1'b1; if_a.req_write = 1'b1; if_a.req_addr = 8'd7;
    if_a.req_wdata = 8'h5A; if_a.req_wmask = 1'b1;
    @(negedge clk);
    n_checks++; if (if_a.wr_done !== 1'b1) begin n_fail++; $display("FAIL raw_wr_done: got %b want 1", if_a.wr_done); end
    if_a.req_write = 1'b0;
    @(negedge clk);
    idle_all();
    n_checks++; if ({if_a.rsp_valid, if_a.rsp_data} !== {1'b1, 8'h5A}) begin
      n_fail++; $display("FAIL raw_read: got %b %h want 1 5a", if_a.rsp_valid, if_a.rsp_data); end
    issue(1'b0, 1'b1, 8'd8, 32'h11, 4'h1);
    issue(1'b0, 1'b1, 8'd9, 32'h22, 4'h1);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if_a.req_valid = 1'b1; if_a.req_write = 1'b0; if_a.req_addr = 8'(7 + k);
      @(negedge clk);
      n_checks++; if ({if_a.rsp_valid, if_a.rsp_data} !== {1'b1, exp_d[k]}) begin
        n_fail++; $display("FAIL b2b_read%0d: got %b %h want 1 %h", k, if_a.rsp_valid, if_a.rsp_data, exp_d[k]); end
    end
    idle_all();
    @(negedge clk);
    n_checks++; if ({if_a.rsp_valid, if_a.rsp_data} !== {1'b0, 8'h22}) begin
      n_fail++; $display("FAIL data_hold: got %b %h want 0 22", if_a.rsp_valid, if_a.rsp_data); end
  endtask

  task automatic test_clear();
    int ca, cb;
    @(negedge clk);
    clear_req_b = 1'b1;
    if_b.req_valid = 1'b1; if_b.req_write = 1'b1; if_b.req_addr = 8'd5;
    if_b.req_wdata = 32'hFFFFFFFF; if_b.req_wmask = 4'hF;
    #1;
    n_checks++; if (if_b.req_ready !== 1'b0) begin n_fail++; $display("FAIL clear_ready: got %b want 0", if_b.req_ready); end
    @(negedge clk);
    clear_req_b = 1'b0;
    idle_all();
    n_checks++; if (if_b.wr_done !== 1'b0) begin n_fail++; $display("FAIL clear_not_accepted: got %b want 0", if_b.wr_done); end
    count_busy(ca, cb);
    n_checks++; if (cb != 200) begin n_fail++; $display("FAIL clear_sweep_len: got %0d want 200", cb); end
    issue(1'b1, 1'b0, 8'd5, 32'h0, 4'h0);
    n_checks++; if (if_b.rsp_data !== 32'h0) begin n_fail++; $display("FAIL clear_addr5: got %h want 00000000", if_b.rsp_data); end
    issue(1'b1, 1'b0, 8'd199, 32'h0, 4'h0);
    n_checks++; if (if_b.rsp_data !== 32'h0) begin n_fail++; $display("FAIL clear_addr199: got %h want 00000000", if_b.rsp_data); end
  endtask

  task automatic test_reset_mid_sweep();
    int ca, cb;
    @(negedge clk);
    clear_req_a = 1'b1;
    @(negedge clk);
    clear_req_a = 1'b0;
    for (int k = 0; k < 50; k++) @(negedge clk);
    if_b.req_valid = 1'b1; if_b.req_write = 1'b0; if_b.req_addr = 8'd5;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    idle_all();
    #1;
    n_checks++; if (if_b.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_drop_rsp: got %b want 0", if_b.rsp_valid); end
    n_checks++; if ({busy_a, if_a.req_ready, if_a.rsp_valid, if_a.rsp_err, if_a.wr_done} !== 5'b10000) begin
      n_fail++; $display("FAIL rst_mid_outputs: got %b want 10000",
                         {busy_a, if_a.req_ready, if_a.rsp_valid, if_a.rsp_err, if_a.wr_done}); end
    n_checks++; if (if_a.rsp_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data: got %h want 00", if_a.rsp_data); end
    @(negedge clk);
    rst_n = 1'b1;
    count_busy(ca, cb);
    n_checks++; if (ca != 256) begin n_fail++; $display("FAIL restart_sweep_len: got %0d want 256", ca); end
    issue(1'b0, 1'b0, 8'd7, 32'h0, 4'h0);
    n_checks++; if ({if_a.rsp_valid, if_a.rsp_data} !== {1'b1, 8'h00}) begin
      n_fail++; $display("FAIL restart_cleared: got %b %h want 1 00", if_a.rsp_valid, if_a.rsp_data); end
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    perr_inj_a = 1'b1;
    issue(1'b0, 1'b1, 8'd3, 32'h0F, 4'h1);
    perr_inj_a = 1'b0;
    issue(1'b0, 1'b0, 8'd3, 32'h0, 4'h0);
    n_checks++; if ({rsp_perr_a, if_a.rsp_data} !== {1'b1, 8'h0F}) begin
      n_fail++; $display("FAIL perr_injected: got %b %h want 1 0f", rsp_perr_a, if_a.rsp_data); end
    @(negedge clk);
    n_checks++; if (rsp_perr_a !== 1'b0) begin n_fail++; $display("FAIL perr_idle: got %b want 0", rsp_perr_a); end
    issue(1'b0, 1'b1, 8'd3, 32'h0F, 4'h1);
    issue(1'b0, 1'b0, 8'd3, 32'h0, 4'h0);
    n_checks++; if (rsp_perr_a !== 1'b0) begin n_fail++; $display("FAIL perr_clean: got %b want 0", rsp_perr_a); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    clear_req_a = 1'b0;
    clear_req_b = 1'b0;
`ifdef DMEM_PARITY_EN
    perr_inj_a = 1'b0;
    perr_inj_b = 1'b0;
`endif
    idle_all();
    test_reset();
    test_lane_mask();
    test_out_of_range();
    test_back_to_back();
    test_clear();
    test_reset_mid_sweep();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
